// File: rtl/typing_scorer_if.sv
// typing_scorer_if: keystroke events and target word into the scorer, next-word request back out
// Signals: key_evt/key_cls/key_letter decoded key press; target_word/target_len current target;
//   word_req one-cycle request for the next target after a commit.
interface typing_scorer_if #(
    parameter int MAX_LEN = 25,
    parameter int LW      = 5
);
    logic                  key_evt;
    logic [1:0]            key_cls;
    logic [LW-1:0]         key_letter;
    logic [MAX_LEN*LW-1:0] target_word;
    logic [4:0]            target_len;
    logic                  word_req;
    modport master (output key_evt, key_cls, key_letter, target_word, target_len, input word_req);
    modport slave  (input key_evt, key_cls, key_letter, target_word, target_len, output word_req);
endinterface

// File: rtl/typing_scorer.sv
// typing_scorer: word buffer, correct-prefix tracker, running totals, game timer and accuracy divider
// Ports: clk/rst_n clock and async active-low reset; clear_i stats clear; run_i run/pause;
//   mode_i/limit_i finish rule (seconds or words); kb key events, target word and word_req;
//   buffer_o/cursor_o/ok_len_o typed word; words_*/chars_* totals; acc_o/acc_busy_o accuracy;
//   elapsed_cs_o game time; finish_o sticky game over.
module typing_scorer #(
    parameter int MAX_LEN  = 25,
    parameter int LW       = 5,
    parameter int CW       = 11,
    parameter int TICK_DIV = 1000000,
    parameter int TW       = 15,
    parameter int MAX_CS   = 18000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  run_i,
    input  logic                  mode_i,
    input  logic [6:0]            limit_i,
    typing_scorer_if.slave        kb,
    output logic [MAX_LEN*LW-1:0] buffer_o,
    output logic [4:0]            cursor_o,
    output logic [4:0]            ok_len_o,
    output logic [CW-1:0]         words_done_o,
    output logic [CW-1:0]         words_hit_o,
    output logic [CW-1:0]         chars_typed_o,
    output logic [CW-1:0]         chars_ok_o,
    output logic [6:0]            acc_o,
    output logic                  acc_busy_o,
    output logic [TW-1:0]         elapsed_cs_o,
    output logic                  finish_o
);
    localparam int NW = CW + 7;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int KW = $clog2(NW + 1);
    localparam logic [4:0]    ML    = 5'(MAX_LEN);
    localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_MAX = TW'(MAX_CS);
    localparam logic [KW-1:0] K_ALL = KW'(NW);

    typedef enum logic {D_IDLE, D_BUSY} div_state_t;

    div_state_t                 dst_q, dst_d;
    logic [MAX_LEN-1:0][LW-1:0] buf_q, buf_d, tgt;
    logic [4:0]                 cur_q, cur_d, ok_q, ok_d;
    logic [CW-1:0]              done_q, done_d, hit_q, hit_d;
    logic [CW-1:0]              typed_q, typed_d, good_q, good_d;
    logic [6:0]                 acc_q, acc_d;
    logic [TW-1:0]              el_q, el_d;
    logic                       fin_q, fin_d, req_q, req_d;
    logic [PW-1:0]              pre_q, pre_d;
    logic [CW-1:0]              rem_q, rem_d;
    logic [NW-1:0]              num_q, num_d;
    logic [CW-1:0]              den_q, den_d;
    logic [KW-1:0]              cnt_q, cnt_d;
    logic [CW:0]                sh;
    logic                       key, tick, commit, ge, time_up, words_up;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? '1 : s[CW-1:0];
    endfunction

    assign tgt = kb.target_word;

    always_comb begin
        buf_d    = buf_q;
        cur_d    = cur_q;
        ok_d     = ok_q;
        done_d   = done_q;
        hit_d    = hit_q;
        typed_d  = typed_q;
        good_d   = good_q;
        acc_d    = acc_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        num_d    = num_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        // restoring divider step: shift in the next dividend bit, subtract when it fits
        sh       = {rem_q, num_q[NW-1]};
        ge       = sh >= {1'b0, den_q};
        key      = kb.key_evt && run_i && !fin_q;
        commit   = key && kb.key_cls == 2'd2 && cur_q != 5'd0;
        tick     = run_i && pre_q == P_TOP;
        time_up  = !mode_i && 32'(el_q) >= 32'(limit_i) * 32'd100;
        words_up = mode_i && limit_i != 7'd0 && done_q == CW'(limit_i);
        if (key && kb.key_cls == 2'd0 && cur_q < ML) begin
            buf_d[cur_q] = kb.key_letter;
            cur_d        = cur_q + 5'd1;
            ok_d         = (ok_q == cur_q && cur_q < kb.target_len && tgt[cur_q] == kb.key_letter) ? ok_q + 5'd1 : ok_q;
        end
        if (key && kb.key_cls == 2'd1 && cur_q != 5'd0) begin
            buf_d[cur_q - 5'd1] = '0;
            cur_d               = cur_q - 5'd1;
            ok_d                = (ok_q == cur_q) ? ok_q - 5'd1 : ok_q;
        end
        if (commit) begin
            done_d  = sat_add(done_q, CW'(1));
            hit_d   = (ok_q == cur_q && cur_q == kb.target_len) ? sat_add(hit_q, CW'(1)) : hit_q;
            typed_d = sat_add(typed_q, CW'(cur_q));
            good_d  = sat_add(good_q, CW'(ok_q));
            buf_d   = '0;
            cur_d   = '0;
            ok_d    = '0;
        end
        req_d = run_i ? commit : req_q;
        pre_d = run_i ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
        el_d  = (tick && !fin_q && el_q < T_MAX) ? el_q + TW'(1) : el_q;
        fin_d = fin_q || (run_i && (time_up || words_up || el_q == T_MAX));
        // a commit always (re)starts the division from the freshly updated totals
        if (commit) begin
            dst_d = (typed_d == '0) ? D_IDLE : D_BUSY;
            acc_d = (typed_d == '0) ? 7'd0 : acc_q;
            num_d = NW'(good_d) * NW'(100);
            den_d = typed_d;
            rem_d = '0;
            cnt_d = K_ALL;
        end else if (dst_q == D_BUSY && run_i) begin
            rem_d = ge ? CW'(sh - {1'b0, den_q}) : sh[CW-1:0];
            num_d = {num_q[NW-2:0], ge};
            cnt_d = cnt_q - KW'(1);
            dst_d = (cnt_q == KW'(1)) ? D_IDLE : D_BUSY;
            acc_d = (cnt_q == KW'(1)) ? ((num_d > NW'(100)) ? 7'd100 : num_d[6:0]) : acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q   <= D_IDLE;
            buf_q   <= '0;
            cur_q   <= '0;
            ok_q    <= '0;
            done_q  <= '0;
            hit_q   <= '0;
            typed_q <= '0;
            good_q  <= '0;
            acc_q   <= '0;
            el_q    <= '0;
            fin_q   <= 1'b0;
            req_q   <= 1'b0;
            pre_q   <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            dst_q   <= D_IDLE;
            buf_q   <= '0;
            cur_q   <= '0;
            ok_q    <= '0;
            done_q  <= '0;
            hit_q   <= '0;
            typed_q <= '0;
            good_q  <= '0;
            acc_q   <= '0;
            el_q    <= '0;
            fin_q   <= 1'b0;
            req_q   <= 1'b0;
            pre_q   <= pre_d;
            rem_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
        end else begin
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            cur_q   <= cur_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            typed_q <= typed_d;
            good_q  <= good_d;
            acc_q   <= acc_d;
            el_q    <= el_d;
            fin_q   <= fin_d;
            req_q   <= req_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            den_q   <= den_d;
            cnt_q   <= cnt_d;
        end
    end

    assign kb.word_req     = req_q;
    assign buffer_o        = buf_q;
    assign cursor_o        = cur_q;
    assign ok_len_o        = ok_q;
    assign words_done_o    = done_q;
    assign words_hit_o     = hit_q;
    assign chars_typed_o   = typed_q;
    assign chars_ok_o      = good_q;
    assign acc_o           = acc_q;
    assign acc_busy_o      = dst_q == D_BUSY;
    assign elapsed_cs_o    = el_q;
    assign finish_o        = fin_q;
endmodule
